// File: rtl/reduce_nxw_seq_pkg.sv
// Shared types for the sequential bitwise reduction unit: reduction opcodes and FSM states.
package reduce_nxw_seq_pkg;

  typedef enum logic [1:0] {
    OP_OR  = 2'b00,
    OP_AND = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } red_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/reduce_nxw_seq_if.sv
// Request/response bundle of the reduction unit: start/op/operands in, busy/done/result/zero out.
interface reduce_nxw_seq_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_OPS = 8
);
  logic                     start;
  logic [1:0]               op;
  logic [NUM_OPS*WIDTH-1:0] operands;
  logic                     busy;
  logic                     done;
  logic [WIDTH-1:0]         result;
  logic                     zero;

  modport master (output start, op, operands, input busy, done, result, zero);
  modport slave  (input start, op, operands, output busy, done, result, zero);
endinterface

// File: rtl/reduce_nxw_seq_lane.sv
// Combinational fold of one group of LANES operands into the running accumulator.
// NOR folds as OR here; the single inversion happens at writeback in the top level.
module reduce_nxw_seq_lane
  import reduce_nxw_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LANES = 2
) (
  input  logic [WIDTH-1:0]       acc,
  input  logic [LANES*WIDTH-1:0] slice,
  input  red_op_e                op,
  output logic [WIDTH-1:0]       acc_next
);

  // NOTE: combinational blocks use blocking assignments and give every output a
  // default first, so the chained fold reads naturally and no latch can be inferred.
  always_comb begin
    acc_next = acc;
    for (int i = 0; i < LANES; i++) begin
      case (op)
        OP_AND:  acc_next = acc_next & slice[i*WIDTH +: WIDTH];
        OP_XOR:  acc_next = acc_next ^ slice[i*WIDTH +: WIDTH];
        default: acc_next = acc_next | slice[i*WIDTH +: WIDTH];
      endcase
    end
  end

endmodule

// File: rtl/reduce_nxw_seq.sv
// Sequential NUM_OPS x WIDTH bitwise reduction (OR/AND/XOR/NOR), LANES operands per cycle,
// with a start/busy/done handshake and a registered zero flag.
module reduce_nxw_seq
  import reduce_nxw_seq_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_OPS = 8,
  parameter int LANES   = 2
) (
  input logic             clk,
  input logic             rst_n,
  reduce_nxw_seq_if.slave bus
);

  localparam int IDXW   = $clog2(NUM_OPS) + 1;
  localparam int GW     = LANES * WIDTH;
  localparam int GROUPS = NUM_OPS / LANES;

  state_e                   state, state_nxt;
  red_op_e                  op_q;
  logic [NUM_OPS*WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0]         acc_q, acc_fold, wb_val, ident, result_q;
  logic [IDXW-1:0]          idx_q;
  logic [GW-1:0]            grp;
  logic                     last_grp, accept, zero_q, busy, done;

  // A request is taken from IDLE or DONE only; start while BUSY is ignored.
  assign accept   = bus.start && (state != ST_BUSY);
  assign last_grp = (32'(idx_q) + LANES) >= NUM_OPS;
  assign ident    = (red_op_e'(bus.op) == OP_AND) ? '1 : '0;
  assign wb_val   = (op_q == OP_NOR) ? ~acc_fold : acc_fold;

  // Group mux keyed on the operand index; only legal group starts ever match.
  always_comb begin
    grp = '0;
    for (int g = 0; g < GROUPS; g++) begin
      if (idx_q == IDXW'(g * LANES)) grp = opnd_q[g*GW +: GW];
    end
  end

  reduce_nxw_seq_lane #(
    .WIDTH (WIDTH),
    .LANES (LANES)
  ) u_lane (
    .acc      (acc_q),
    .slice    (grp),
    .op       (op_q),
    .acc_next (acc_fold)
  );

  // NOTE: every clocked process uses non-blocking assignments so all registers
  // update from pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: if (bus.start) state_nxt = ST_BUSY;
      ST_BUSY: begin
        busy = 1'b1;
        if (last_grp) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = bus.start ? ST_BUSY : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: the operand store is a plain register bank (not a RAM), so it is cleared
  // on reset like the rest of the state and nothing stale can ever be folded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_OR;
      opnd_q   <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else if (accept) begin
      op_q   <= red_op_e'(bus.op);
      opnd_q <= bus.operands;
      acc_q  <= ident;
      idx_q  <= '0;
    end else if (state == ST_BUSY) begin
      acc_q <= acc_fold;
      // Saturate at NUM_OPS instead of wrapping back onto group 0.
      idx_q <= last_grp ? IDXW'(NUM_OPS) : idx_q + IDXW'(LANES);
      if (last_grp) begin
        result_q <= wb_val;
        zero_q   <= (wb_val == '0);
      end
    end
  end

  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.result = result_q;
  assign bus.zero   = zero_q;

endmodule
